sb_rx_deframer: RTL and testbench

Sideband receive deframer, the stage directly downstream of the sideband receive pin that the logical layer's `sbrx` input is driven from. It samples the serial sideband line one bit per `sb_clk` cycle, recovers 10-bit symbols (start, 8 data LSB-first, stop), strips DLE/STX … DLE/ETX framing and DLE stuffing, and presents payload bytes with start/end-of-packet markers to the sideband transaction handler. Line errors, protocol violations and oversize packets are reported as one-cycle error pulses with a cause code.

---
 rtl/sb_rx_deframer_if.sv | 19 +
 rtl/sb_rx_deframer.sv | 307 ++++++++++++++++++++++++++++++
 tb/tb_sb_rx_deframer.sv | 305 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sb_rx_deframer_if.sv
// Receive-side payload bus of the sideband deframer.
// master: the deframer driving bytes, markers and error pulses.
// slave:  the sideband transaction handler consuming them.
interface sb_rx_deframer_if;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       rx_sop;
   logic       rx_eop;
   logic       rx_err;
   logic [1:0] rx_err_code;

   modport master (
      output rx_data, rx_valid, rx_sop, rx_eop, rx_err, rx_err_code
   );

   modport slave (
      input rx_data, rx_valid, rx_sop, rx_eop, rx_err, rx_err_code
   );
endinterface

// File: rtl/sb_rx_deframer.sv
// Sideband receive deframer.
// Samples the serial sideband line one bit per sb_clk cycle and recovers
// 10-bit symbols (start, 8 data bits LSB-first, stop). It strips the
// DLE/STX ... DLE/ETX framing and the DLE stuffing, and delivers payload bytes
// with start/end-of-packet markers. Payload bytes lag by one symbol through a
// one-byte holding register so that the last byte can carry rx_eop.
// Optional feature: define SB_RX_CRC_EN to check a trailing CRC-16
// (poly 8005, init FFFF, MSB-first, low byte sent first) at end of packet.
module sb_rx_deframer #(
   parameter int         MAX_LEN = 64,
   parameter logic [7:0] DLE     = 8'hFE,
   parameter logic [7:0] STX     = 8'h05,
   parameter logic [7:0] ETX     = 8'h40
) (
   input  logic sb_clk,
   input  logic rst,
   input  logic sbrx,
   sb_rx_deframer_if.master bus
);

   localparam int CW = $clog2(MAX_LEN + 2);

   localparam logic [1:0] ERR_STOP  = 2'd0;
   localparam logic [1:0] ERR_PROTO = 2'd1;
   localparam logic [1:0] ERR_OVF   = 2'd2;
`ifdef SB_RX_CRC_EN
   localparam logic [1:0] ERR_CRC   = 2'd3;
`endif

   typedef enum logic [1:0] {S_IDLE, S_DATA, S_STOP} sym_state_t;
   typedef enum logic [1:0] {D_HUNT, D_HDLE, D_INPKT, D_PDLE} df_state_t;

   // ---------------- symbol recovery ----------------
   sym_state_t sym_state_reg, sym_state_next;
   logic [2:0] bit_cnt_reg, bit_cnt_next;
   logic       shift_reg [8];
   logic [7:0] sym_byte;
   logic       sym_good;
   logic       sym_bad;

   // Symbol state register and data-bit counter.
   always_ff @(posedge sb_clk) begin
      if (!rst) begin
         sym_state_reg <= S_IDLE;
         bit_cnt_reg   <= 3'd0;
      end else begin
         sym_state_reg <= sym_state_next;
         bit_cnt_reg   <= bit_cnt_next;
      end
   end

   // Symbol next state; the stop bit sample flags the symbol good or bad.
   always_comb begin
      sym_state_next = sym_state_reg;
      bit_cnt_next   = bit_cnt_reg;
      sym_good       = 1'b0;
      sym_bad        = 1'b0;
      case (sym_state_reg)
         S_IDLE: begin
            if (!sbrx) begin
               sym_state_next = S_DATA;
               bit_cnt_next   = 3'd0;
            end
         end
         S_DATA: begin
            bit_cnt_next = bit_cnt_reg + 3'd1;
            if (bit_cnt_reg == 3'd7) begin
               sym_state_next = S_STOP;
            end
         end
         S_STOP: begin
            sym_state_next = S_IDLE;
            if (sbrx) begin
               sym_good = 1'b1;
            end else begin
               sym_bad = 1'b1;
            end
         end
         default: sym_state_next = S_IDLE;
      endcase
   end

   genvar gi;
   generate
      for (gi = 0; gi < 8; gi++) begin : g_bit
         // Data bit gi of the symbol is captured on its own sample cycle.
         always_ff @(posedge sb_clk) begin
            if (!rst) begin
               shift_reg[gi] <= 1'b0;
            end else if (sym_state_reg == S_DATA && bit_cnt_reg == 3'(gi)) begin
               shift_reg[gi] <= sbrx;
            end
         end
         assign sym_byte[gi] = shift_reg[gi];
      end
   endgenerate

   // ---------------- deframer ----------------
   df_state_t  df_state_reg, df_state_next;
   logic [CW-1:0] count_reg, count_next;
   logic [7:0] hold_data_reg, hold_data_next;
   logic       hold_full_reg, hold_full_next;
   logic       hold_first_reg, hold_first_next;

   logic [7:0] data_reg, data_next;
   logic       valid_reg, valid_next;
   logic       sop_reg, sop_next;
   logic       eop_reg, eop_next;
   logic       err_reg, err_next;
   logic [1:0] code_reg, code_next;

   logic       is_data;
   logic       do_end;
   logic [7:0] data_byte;

`ifdef SB_RX_CRC_EN
   // CRC over every payload byte except the final two, which are the CRC.
   logic [15:0] crc_reg, crc_next;
   logic [7:0]  prev_data_reg, prev_data_next;

   function automatic logic [15:0] crc_step(input logic [15:0] crc, input logic [7:0] b);
      logic [15:0] c;
      c = crc ^ {b, 8'h00};
      for (int i = 0; i < 8; i++) begin
         c = c[15] ? ((c << 1) ^ 16'h8005) : (c << 1);
      end
      return c;
   endfunction
`endif

   // Deframer state, holding register and registered outputs.
   always_ff @(posedge sb_clk) begin
      if (!rst) begin
         df_state_reg   <= D_HUNT;
         count_reg      <= '0;
         hold_data_reg  <= 8'h00;
         hold_full_reg  <= 1'b0;
         hold_first_reg <= 1'b0;
         data_reg       <= 8'h00;
         valid_reg      <= 1'b0;
         sop_reg        <= 1'b0;
         eop_reg        <= 1'b0;
         err_reg        <= 1'b0;
         code_reg       <= 2'd0;
`ifdef SB_RX_CRC_EN
         crc_reg        <= 16'hFFFF;
         prev_data_reg  <= 8'h00;
`endif
      end else begin
         df_state_reg   <= df_state_next;
         count_reg      <= count_next;
         hold_data_reg  <= hold_data_next;
         hold_full_reg  <= hold_full_next;
         hold_first_reg <= hold_first_next;
         data_reg       <= data_next;
         valid_reg      <= valid_next;
         sop_reg        <= sop_next;
         eop_reg        <= eop_next;
         err_reg        <= err_next;
         code_reg       <= code_next;
`ifdef SB_RX_CRC_EN
         crc_reg        <= crc_next;
         prev_data_reg  <= prev_data_next;
`endif
      end
   end

   // Deframer next state, unstuffing, byte emission and error reporting.
   always_comb begin
      df_state_next   = df_state_reg;
      count_next      = count_reg;
      hold_data_next  = hold_data_reg;
      hold_full_next  = hold_full_reg;
      hold_first_next = hold_first_reg;
      data_next       = 8'h00;
      valid_next      = 1'b0;
      sop_next        = 1'b0;
      eop_next        = 1'b0;
      err_next        = 1'b0;
      code_next       = 2'd0;
      is_data         = 1'b0;
      do_end          = 1'b0;
      data_byte       = sym_byte;
`ifdef SB_RX_CRC_EN
      crc_next        = crc_reg;
      prev_data_next  = prev_data_reg;
`endif

      if (sym_bad) begin
         // A broken symbol only matters once a packet is open.
         case (df_state_reg)
            D_INPKT, D_PDLE: begin
               err_next       = 1'b1;
               code_next      = ERR_STOP;
               df_state_next  = D_HUNT;
               hold_full_next = 1'b0;
            end
            D_HDLE:  df_state_next = D_HUNT;
            default: ;
         endcase
      end else if (sym_good) begin
         case (df_state_reg)
            D_HUNT: begin
               if (sym_byte == DLE) df_state_next = D_HDLE;
            end
            D_HDLE: begin
               if (sym_byte == STX) begin
                  df_state_next  = D_INPKT;
                  count_next     = '0;
                  hold_full_next = 1'b0;
`ifdef SB_RX_CRC_EN
                  crc_next       = 16'hFFFF;
`endif
               end else if (sym_byte != DLE) begin
                  df_state_next = D_HUNT;
               end
            end
            D_INPKT: begin
               if (sym_byte == DLE) begin
                  df_state_next = D_PDLE;
               end else begin
                  is_data = 1'b1;
               end
            end
            D_PDLE: begin
               if (sym_byte == DLE) begin
                  is_data   = 1'b1;
                  data_byte = DLE;
               end else if (sym_byte == ETX) begin
                  do_end = 1'b1;
               end else if (sym_byte == STX) begin
                  // Restart: the unfinished packet is abandoned.
                  err_next       = 1'b1;
                  code_next      = ERR_PROTO;
                  df_state_next  = D_INPKT;
                  count_next     = '0;
                  hold_full_next = 1'b0;
`ifdef SB_RX_CRC_EN
                  crc_next       = 16'hFFFF;
`endif
               end else begin
                  err_next       = 1'b1;
                  code_next      = ERR_PROTO;
                  df_state_next  = D_HUNT;
                  hold_full_next = 1'b0;
               end
            end
            default: df_state_next = D_HUNT;
         endcase
      end

      if (is_data) begin
         if (count_reg == CW'(MAX_LEN)) begin
            // One byte too many: drop the packet, held byte included.
            err_next       = 1'b1;
            code_next      = ERR_OVF;
            df_state_next  = D_HUNT;
            hold_full_next = 1'b0;
         end else begin
            count_next    = count_reg + CW'(1);
            df_state_next = D_INPKT;
            if (hold_full_reg) begin
               valid_next = 1'b1;
               data_next  = hold_data_reg;
               sop_next   = hold_first_reg;
`ifdef SB_RX_CRC_EN
               // Byte two behind the newest is now known not to be CRC.
               if (count_reg >= CW'(2)) crc_next = crc_step(crc_reg, prev_data_reg);
               prev_data_next = hold_data_reg;
`endif
            end
            hold_data_next  = data_byte;
            hold_first_next = !hold_full_reg;
            hold_full_next  = 1'b1;
         end
      end

      if (do_end) begin
         df_state_next  = D_HUNT;
         hold_full_next = 1'b0;
         if (hold_full_reg) begin
            valid_next = 1'b1;
            data_next  = hold_data_reg;
            sop_next   = hold_first_reg;
            eop_next   = 1'b1;
`ifdef SB_RX_CRC_EN
            // Held byte is the CRC high byte, prev_data the low byte.
            if (count_reg < CW'(3) || crc_reg != {hold_data_reg, prev_data_reg}) begin
               err_next  = 1'b1;
               code_next = ERR_CRC;
            end
`endif
         end else begin
            err_next  = 1'b1;
            code_next = ERR_PROTO;
         end
      end
   end

   assign bus.rx_data     = data_reg;
   assign bus.rx_valid    = valid_reg;
   assign bus.rx_sop      = sop_reg;
   assign bus.rx_eop      = eop_reg;
   assign bus.rx_err      = err_reg;
   assign bus.rx_err_code = code_reg;

endmodule

// File: tb/tb_sb_rx_deframer.sv
// Self-checking bench for sb_rx_deframer: symbol vectors from a table plus
// hand-written overflow, reset and CRC sequences; expected output events go
// into a scoreboard queue and are matched in order as the DUT strobes.
module tb_sb_rx_deframer;

   logic sb_clk = 1'b0;
   logic rst    = 1'b0;
   logic sbrx   = 1'b1;

   sb_rx_deframer_if bus ();

   sb_rx_deframer #(.MAX_LEN(64)) dut (
      .sb_clk (sb_clk),
      .rst    (rst),
      .sbrx   (sbrx),
      .bus    (bus)
   );

   always #5 sb_clk = ~sb_clk;

`ifdef SB_RX_CRC_EN
   localparam bit CRC_ON = 1'b1;
`else
   localparam bit CRC_ON = 1'b0;
`endif

   typedef struct packed {
      logic       valid;
      logic [7:0] data;
      logic       sop;
      logic       eop;
      logic       err;
      logic [1:0] code;
   } ev_t;

   typedef struct {
      logic [7:0] sym;
      logic       stop;
      logic       has_exp;
      ev_t        ev;
   } vec_t;

   ev_t  exp_q [$];
   vec_t vt [$];
   int   checks = 0;
   int   errors = 0;
   ev_t  act_ev;
   ev_t  exp_ev;
   ev_t  cur_ev;

   function automatic ev_t dat(input logic [7:0] d, input logic sop, input logic eop);
      ev_t e;
      e.valid = 1'b1;
      e.data  = d;
      e.sop   = sop;
      e.eop   = eop;
      // Plain test packets carry no valid CRC, so a CRC build flags them.
      e.err   = CRC_ON & eop;
      e.code  = (CRC_ON & eop) ? 2'd3 : 2'd0;
      return e;
   endfunction

   function automatic ev_t errev(input logic [1:0] c);
      ev_t e;
      e.valid = 1'b0;
      e.data  = 8'h00;
      e.sop   = 1'b0;
      e.eop   = 1'b0;
      e.err   = 1'b1;
      e.code  = c;
      return e;
   endfunction

   function automatic vec_t vn(input logic [7:0] s, input logic stop);
      vec_t v;
      v.sym = s; v.stop = stop; v.has_exp = 1'b0; v.ev = '0;
      return v;
   endfunction

   function automatic vec_t ve(input logic [7:0] s, input logic stop, input ev_t e);
      vec_t v;
      v.sym = s; v.stop = stop; v.has_exp = 1'b1; v.ev = e;
      return v;
   endfunction

   function automatic logic [15:0] ref_crc(input logic [7:0] b0, input logic [7:0] b1);
      logic [15:0] c;
      logic [7:0]  bytes [2];
      bytes[0] = b0;
      bytes[1] = b1;
      c = 16'hFFFF;
      for (int k = 0; k < 2; k++) begin
         for (int i = 7; i >= 0; i--) begin
            if (c[15] ^ bytes[k][i]) c = (c << 1) ^ 16'h8005;
            else                     c = c << 1;
         end
      end
      return c;
   endfunction

   task automatic send_bit(input logic v);
      sbrx = v;
      @(posedge sb_clk);
      #1;
   endtask

   task automatic send_sym(input logic [7:0] b, input logic stop);
      send_bit(1'b0);
      for (int i = 0; i < 8; i++) send_bit(b[i]);
      send_bit(stop);
   endtask

   task automatic send_payload(input logic [7:0] b);
      if (b == 8'hFE) send_sym(8'hFE, 1'b1);
      send_sym(b, 1'b1);
   endtask

   // Scoreboard: every strobe must match the oldest outstanding expectation.
   always @(negedge sb_clk) begin
      if (rst && (bus.rx_valid || bus.rx_err)) begin
         act_ev = {bus.rx_valid, bus.rx_data, bus.rx_sop, bus.rx_eop, bus.rx_err, bus.rx_err_code};
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_event got v=%b d=%h sop=%b eop=%b err=%b code=%0d expected none",
                     act_ev.valid, act_ev.data, act_ev.sop, act_ev.eop, act_ev.err, act_ev.code);
         end else begin
            exp_ev = exp_q.pop_front();
            if (act_ev !== exp_ev) begin
               errors++;
               $display("FAIL event got v=%b d=%h sop=%b eop=%b err=%b code=%0d expected v=%b d=%h sop=%b eop=%b err=%b code=%0d",
                        act_ev.valid, act_ev.data, act_ev.sop, act_ev.eop, act_ev.err, act_ev.code,
                        exp_ev.valid, exp_ev.data, exp_ev.sop, exp_ev.eop, exp_ev.err, exp_ev.code);
            end else begin
               $display("ok   event v=%b d=%h sop=%b eop=%b err=%b code=%0d",
                        act_ev.valid, act_ev.data, act_ev.sop, act_ev.eop, act_ev.err, act_ev.code);
            end
         end
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog timeout");
      $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
      $fatal(1, "timeout");
   end

   initial begin
      logic [15:0] crc;

      // ---- reset state ----
      rst  = 1'b0;
      sbrx = 1'b1;
      repeat (3) @(posedge sb_clk);
      #1;
      cur_ev = {bus.rx_valid, bus.rx_data, bus.rx_sop, bus.rx_eop, bus.rx_err, bus.rx_err_code};
      checks++;
      if (cur_ev !== '0) begin
         errors++;
         $display("FAIL reset_outputs got %h expected 0", cur_ev);
      end else begin
         $display("ok   reset_outputs");
      end
      rst = 1'b1;
      repeat (2) send_bit(1'b1);

      // ---- table of symbol vectors ----
      // basic packet
      vt.push_back(vn(8'hFE, 1)); vt.push_back(vn(8'h05, 1));
      vt.push_back(vn(8'h11, 1));
      vt.push_back(ve(8'h22, 1, dat(8'h11, 1, 0)));
      vt.push_back(ve(8'h33, 1, dat(8'h22, 0, 0)));
      vt.push_back(vn(8'hFE, 1));
      vt.push_back(ve(8'h40, 1, dat(8'h33, 0, 1)));
      // stuffed DLE in payload
      vt.push_back(vn(8'hFE, 1)); vt.push_back(vn(8'h05, 1));
      vt.push_back(vn(8'hAA, 1));
      vt.push_back(vn(8'hFE, 1));
      vt.push_back(ve(8'hFE, 1, dat(8'hAA, 1, 0)));
      vt.push_back(ve(8'hBB, 1, dat(8'hFE, 0, 0)));
      vt.push_back(vn(8'hFE, 1));
      vt.push_back(ve(8'h40, 1, dat(8'hBB, 0, 1)));
      // stop error mid-packet, held byte dropped, next packet fine
      vt.push_back(vn(8'hFE, 1)); vt.push_back(vn(8'h05, 1));
      vt.push_back(vn(8'h11, 1));
      vt.push_back(ve(8'h55, 0, errev(2'd0)));
      vt.push_back(vn(8'hFE, 1)); vt.push_back(vn(8'h05, 1));
      vt.push_back(vn(8'h22, 1));
      vt.push_back(vn(8'hFE, 1));
      vt.push_back(ve(8'h40, 1, dat(8'h22, 1, 1)));
      // empty packet
      vt.push_back(vn(8'hFE, 1)); vt.push_back(vn(8'h05, 1));
      vt.push_back(vn(8'hFE, 1));
      vt.push_back(ve(8'h40, 1, errev(2'd1)));
      // DLE STX restart inside a packet
      vt.push_back(vn(8'hFE, 1)); vt.push_back(vn(8'h05, 1));
      vt.push_back(vn(8'h11, 1));
      vt.push_back(vn(8'hFE, 1));
      vt.push_back(ve(8'h05, 1, errev(2'd1)));
      vt.push_back(vn(8'h22, 1));
      vt.push_back(vn(8'hFE, 1));
      vt.push_back(ve(8'h40, 1, dat(8'h22, 1, 1)));
      // stop error while hunting is silent; DLE DLE STX still opens a packet
      vt.push_back(vn(8'h00, 0));
      vt.push_back(vn(8'hFE, 1)); vt.push_back(vn(8'hFE, 1)); vt.push_back(vn(8'h05, 1));
      vt.push_back(vn(8'h33, 1));
      vt.push_back(vn(8'hFE, 1));
      vt.push_back(ve(8'h40, 1, dat(8'h33, 1, 1)));
      // DLE followed by an unknown command byte
      vt.push_back(vn(8'hFE, 1)); vt.push_back(vn(8'h05, 1));
      vt.push_back(vn(8'h44, 1));
      vt.push_back(vn(8'hFE, 1));
      vt.push_back(ve(8'h12, 1, errev(2'd1)));

      foreach (vt[i]) begin
         if (vt[i].has_exp) exp_q.push_back(vt[i].ev);
         send_sym(vt[i].sym, vt[i].stop);
      end
      repeat (3) send_bit(1'b1);

      // ---- overflow: 65 bytes with MAX_LEN = 64 ----
      send_sym(8'hFE, 1); send_sym(8'h05, 1);
      for (int k = 1; k <= 65; k++) begin
         if (k >= 2 && k <= 64) exp_q.push_back(dat(8'h00, k == 2, 0));
         if (k == 65) exp_q.push_back(errev(2'd2));
         send_sym(8'h00, 1);
      end
      exp_q.push_back(dat(8'h77, 1, 1));
      send_sym(8'hFE, 1); send_sym(8'h05, 1); send_sym(8'h77, 1);
      send_sym(8'hFE, 1); send_sym(8'h40, 1);
      repeat (3) send_bit(1'b1);

      // ---- reset mid-payload ----
      send_sym(8'hFE, 1); send_sym(8'h05, 1); send_sym(8'h11, 1);
      send_sym(8'h22, 1);
      cur_ev = {bus.rx_valid, bus.rx_data, bus.rx_sop, bus.rx_eop, bus.rx_err, bus.rx_err_code};
      checks++;
      if (cur_ev !== dat(8'h11, 1, 0)) begin
         errors++;
         $display("FAIL pre_reset_strobe got %h expected %h", cur_ev, dat(8'h11, 1, 0));
      end else begin
         $display("ok   pre_reset_strobe");
      end
      rst = 1'b0;
      sbrx = 1'b0;
      @(posedge sb_clk);
      #1;
      cur_ev = {bus.rx_valid, bus.rx_data, bus.rx_sop, bus.rx_eop, bus.rx_err, bus.rx_err_code};
      checks++;
      if (cur_ev !== '0) begin
         errors++;
         $display("FAIL reset_mid_packet got %h expected 0", cur_ev);
      end else begin
         $display("ok   reset_mid_packet");
      end
      send_sym(8'h5A, 1);
      rst = 1'b1;
      repeat (2) send_bit(1'b1);
      exp_q.push_back(dat(8'h33, 1, 1));
      send_sym(8'hFE, 1); send_sym(8'h05, 1); send_sym(8'h33, 1);
      send_sym(8'hFE, 1); send_sym(8'h40, 1);
      repeat (3) send_bit(1'b1);

`ifdef SB_RX_CRC_EN
      // ---- CRC good and corrupted ----
      crc = ref_crc(8'h01, 8'h02);
      exp_q.push_back({1'b1, 8'h01, 1'b1, 1'b0, 1'b0, 2'd0});
      exp_q.push_back({1'b1, 8'h02, 1'b0, 1'b0, 1'b0, 2'd0});
      exp_q.push_back({1'b1, crc[7:0], 1'b0, 1'b0, 1'b0, 2'd0});
      exp_q.push_back({1'b1, crc[15:8], 1'b0, 1'b1, 1'b0, 2'd0});
      send_sym(8'hFE, 1); send_sym(8'h05, 1);
      send_payload(8'h01); send_payload(8'h02);
      send_payload(crc[7:0]); send_payload(crc[15:8]);
      send_sym(8'hFE, 1); send_sym(8'h40, 1);
      repeat (3) send_bit(1'b1);

      exp_q.push_back({1'b1, 8'h01, 1'b1, 1'b0, 1'b0, 2'd0});
      exp_q.push_back({1'b1, 8'h02, 1'b0, 1'b0, 1'b0, 2'd0});
      exp_q.push_back({1'b1, crc[7:0] ^ 8'h01, 1'b0, 1'b0, 1'b0, 2'd0});
      exp_q.push_back({1'b1, crc[15:8], 1'b0, 1'b1, 1'b1, 2'd3});
      send_sym(8'hFE, 1); send_sym(8'h05, 1);
      send_payload(8'h01); send_payload(8'h02);
      send_payload(crc[7:0] ^ 8'h01); send_payload(crc[15:8]);
      send_sym(8'hFE, 1); send_sym(8'h40, 1);
      repeat (3) send_bit(1'b1);
`else
      crc = ref_crc(8'h01, 8'h02);
`endif

      // ---- drain: every expected event must have appeared ----
      repeat (20) send_bit(1'b1);
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL missing_events got %0d outstanding expected 0 (crc ref %h)", exp_q.size(), crc);
      end else begin
         $display("ok   all_events_seen");
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
